alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 20 ++
 rtl/alu_arbiter_alu.sv | 26 ++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and ALU control constants for the ALU arbiter
package alu_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    localparam logic [5:0] CTRL_ADD       = 6'b000010;
    localparam logic [5:0] CTRL_AND       = 6'b000000;
    localparam logic [5:0] CTRL_X_MINUS_1 = 6'b001110;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational Hack ALU (zx,nx,zy,ny,f,no)
module alu_arbiter_alu
    import alu_arb_pkg::*;
(
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [5:0]  ctrl_i,
    output logic [15:0] out_o,
    output logic        zr_o,
    output logic        ng_o
);

    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    always_comb begin
        x_z   = ctrl_i[CTRL_ZX] ? 16'h0000 : x_i;
        x_n   = ctrl_i[CTRL_NX] ? ~x_z : x_z;
        y_z   = ctrl_i[CTRL_ZY] ? 16'h0000 : y_i;
        y_n   = ctrl_i[CTRL_NY] ? ~y_z : y_z;
        f_out = ctrl_i[CTRL_F] ? (x_n + y_n) : (x_n & y_n);
        out_o = ctrl_i[CTRL_NO] ? ~f_out : f_out;
        zr_o  = (out_o == 16'h0000);
        ng_o  = out_o[15];
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin front end sharing one Hack ALU, single result register
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [15:0]      req0_x,
    input  logic [15:0]      req0_y,
    input  logic [15:0]      req1_x,
    input  logic [15:0]      req1_y,
    input  logic [5:0]       req0_ctrl,
    input  logic [5:0]       req1_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_out,
    output logic             rsp_zr,
    output logic             rsp_ng,
    output logic             rsp_id,
    output logic [CNT_W-1:0] gnt0_cnt,
    output logic [CNT_W-1:0] gnt1_cnt
);

    arb_state_e       state_q, state_d;
    logic             last_q;
    logic             grant;
    logic             accept_en;
    logic             fire;
    logic [15:0]      alu_x, alu_y, alu_out;
    logic [5:0]       alu_ctrl;
    logic             alu_zr, alu_ng;
    logic [15:0]      out_q;
    logic             zr_q, ng_q, id_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // A lone requester always wins; on a tie the port not served last goes next.
    always_comb begin
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else begin
            grant = ~last_q;
        end
    end

    assign rsp_valid  = (state_q == ST_FULL);
    assign accept_en  = rst_n && ((state_q == ST_EMPTY) || (rsp_valid && rsp_ready));
    assign req0_ready = accept_en && !grant;
    assign req1_ready = accept_en && grant;
    assign fire       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign alu_x    = grant ? req1_x    : req0_x;
    assign alu_y    = grant ? req1_y    : req0_y;
    assign alu_ctrl = grant ? req1_ctrl : req0_ctrl;

    alu_arbiter_alu u_alu (
        .x_i    (alu_x),
        .y_i    (alu_y),
        .ctrl_i (alu_ctrl),
        .out_o  (alu_out),
        .zr_o   (alu_zr),
        .ng_o   (alu_ng)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (fire) state_d = ST_FULL;
            ST_FULL:  if (!fire && rsp_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= 16'h0000;
            zr_q   <= 1'b0;
            ng_q   <= 1'b0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (fire) begin
            out_q  <= alu_out;
            zr_q   <= alu_zr;
            ng_q   <= alu_ng;
            id_q   <= grant;
            last_q <= grant;
            if (grant) begin
                cnt1_q <= cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt0_q <= cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign rsp_out  = out_q;
    assign rsp_zr   = zr_q;
    assign rsp_ng   = ng_q;
    assign rsp_id   = id_q;
    assign gnt0_cnt = cnt0_q;
    assign gnt1_cnt = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0]      req0_x, req0_y, req1_x, req1_y;
    logic [5:0]       req0_ctrl, req1_ctrl;
    logic             rsp_valid, rsp_ready, rsp_zr, rsp_ng, rsp_id;
    logic [15:0]      rsp_out;
    logic [CNT_W-1:0] gnt0_cnt, gnt1_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // model of the result register and arbitration history
    bit          m_full = 1'b0;
    bit [15:0]   m_out  = 16'h0;
    bit          m_zr = 1'b0, m_ng = 1'b0, m_id = 1'b0;
    bit          m_last = 1'b1;
    int          m_cnt0 = 0, m_cnt1 = 0;

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req0_ctrl  (req0_ctrl),
        .req1_ctrl  (req1_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out    (rsp_out),
        .rsp_zr     (rsp_zr),
        .rsp_ng     (rsp_ng),
        .rsp_id     (rsp_id),
        .gnt0_cnt   (gnt0_cnt),
        .gnt1_cnt   (gnt1_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit [15:0] hack(input bit [15:0] x, input bit [15:0] y, input bit [5:0] c);
        bit [15:0] a, b, r;
        a = c[5] ? 16'h0 : x;
        if (c[4]) a = 16'hFFFF - a;
        b = c[3] ? 16'h0 : y;
        if (c[2]) b = 16'hFFFF - b;
        r = c[1] ? 16'(a + b) : (a & b);
        if (c[0]) r = 16'hFFFF - r;
        return r;
    endfunction

    function automatic bit pick(input bit v0, input bit v1, input bit last);
        if (v0 != v1) return v1;
        return !last;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 1'b0; m_out = 16'h0; m_zr = 1'b0; m_ng = 1'b0; m_id = 1'b0;
            m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            bit g;
            g = pick(req0_valid, req1_valid, m_last);
            if ((!m_full || rsp_ready) && (g ? req1_valid : req0_valid)) begin
                m_out  = g ? hack(req1_x, req1_y, req1_ctrl) : hack(req0_x, req0_y, req0_ctrl);
                m_zr   = (m_out == 16'h0);
                m_ng   = (m_out >= 16'h8000);
                m_id   = g;
                m_last = g;
                m_full = 1'b1;
                if (g) m_cnt1 = (m_cnt1 + 1) % 256;
                else   m_cnt0 = (m_cnt0 + 1) % 256;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit acc, g;
            acc = rst_n && (!m_full || rsp_ready);
            g   = pick(req0_valid, req1_valid, m_last);
            chk("rsp_valid",  rsp_valid,  m_full);
            chk("rsp_out",    rsp_out,    m_out);
            chk("rsp_zr",     rsp_zr,     m_zr);
            chk("rsp_ng",     rsp_ng,     m_ng);
            chk("rsp_id",     rsp_id,     m_id);
            chk("req0_ready", req0_ready, acc && !g);
            chk("req1_ready", req1_ready, acc && g);
            chk("gnt0_cnt",   gnt0_cnt,   m_cnt0);
            chk("gnt1_cnt",   gnt1_cnt,   m_cnt1);
        end
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_x = 0; req0_y = 0; req1_x = 0; req1_y = 0; req0_ctrl = 0; req1_ctrl = 0;
        #1;
        started = 1'b1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_out", rsp_out, 0);
        chk("reset_ready0", req0_ready, 0);
        chk("reset_cnt0", gnt0_cnt, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // single ADD on port 0
        req0_valid = 1; req0_x = 3; req0_y = 2; req0_ctrl = CTRL_ADD; rsp_ready = 1;
        step();
        chk("add_valid", rsp_valid, 1);
        chk("add_out", rsp_out, 5);
        chk("add_zr", rsp_zr, 0);
        chk("add_ng", rsp_ng, 0);
        chk("add_id", rsp_id, 0);
        chk("add_cnt0", gnt0_cnt, 1);
        req0_valid = 0;
        step();
        chk("drained", rsp_valid, 0);

        // tie after reset: port 0 first, then port 1
        rst_n = 0; #1 rst_n = 1;
        req0_valid = 1; req0_x = 1; req0_y = 1; req0_ctrl = CTRL_ADD;
        req1_valid = 1; req1_x = 16'hFFFF; req1_y = 16'h0F0F; req1_ctrl = CTRL_AND;
        step();
        chk("tie1_out", rsp_out, 2);
        chk("tie1_id", rsp_id, 0);
        step();
        chk("tie2_out", rsp_out, 16'h0F0F);
        chk("tie2_id", rsp_id, 1);
        req0_valid = 0; req1_valid = 0;
        step();

        // backpressure holds the result, then drain and accept together
        rsp_ready = 0;
        req0_valid = 1; req0_x = 7; req0_y = 1; req0_ctrl = CTRL_ADD;
        step();
        chk("bp_first", rsp_out, 8);
        req0_x = 9;
        repeat (3) begin
            chk("bp_ready0", req0_ready, 0);
            step();
            chk("bp_hold", rsp_out, 8);
            chk("bp_valid", rsp_valid, 1);
        end
        rsp_ready = 1; #1;
        chk("bp_ready_release", req0_ready, 1);
        step();
        chk("bp_new", rsp_out, 10);
        chk("bp_new_valid", rsp_valid, 1);
        req0_valid = 0;
        step();

        // flag boundaries
        req1_valid = 1; req1_x = 16'h8000; req1_y = 0; req1_ctrl = CTRL_ADD;
        step();
        chk("neg_out", rsp_out, 16'h8000);
        chk("neg_ng", rsp_ng, 1);
        chk("neg_zr", rsp_zr, 0);
        req1_x = 0;
        step();
        chk("zero_out", rsp_out, 0);
        chk("zero_zr", rsp_zr, 1);
        req1_valid = 0;
        req0_valid = 1; req0_x = 5; req0_y = 16'h1234; req0_ctrl = CTRL_X_MINUS_1;
        step();
        chk("xm1_out", rsp_out, 4);
        req0_valid = 0;
        step();

        // reset while a result is held
        rsp_ready = 0;
        req0_valid = 1; req0_x = 1; req0_y = 1; req0_ctrl = CTRL_ADD;
        step();
        req0_valid = 0;
        #1 rst_n = 0;
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_out", rsp_out, 0);
        chk("rst_cnt0", gnt0_cnt, 0);
        chk("rst_cnt1", gnt1_cnt, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        step();
        #1 rst_n = 1;
        step();
        chk("rst_no_stale", rsp_valid, 0);
        rsp_ready = 1;

        // counter wrap
        req0_valid = 1;
        for (int i = 0; i < 255; i++) begin
            req0_x = 16'($urandom); req0_y = 16'($urandom); req0_ctrl = 6'($urandom);
            step();
        end
        chk("cnt0_255", gnt0_cnt, 255);
        step();
        chk("cnt0_wrap", gnt0_cnt, 0);
        req0_valid = 0;
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req0_x = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            req0_y = 16'($urandom);
            req1_x = 16'($urandom);
            req1_y = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            req0_ctrl = 6'($urandom);
            req1_ctrl = 6'($urandom);
            step();
        end
        req0_valid = 0; req1_valid = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
